nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_adder_pkg.sv | 13 +
 rtl/CLA_4bit.sv | 32 +++
 rtl/nibble_serial_adder.sv | 111 +++++++++++
 tb/tb_nibble_serial_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the control FSM state encoding and the slice width.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nibble_adder_pkg

// File: rtl/CLA_4bit.sv
// 4-bit carry-lookahead adder slice with group propagate/generate outputs.
// All carries are formed in parallel from bit-level generate/propagate terms.
module CLA_4bit (
  output logic [3:0] S,
  output logic       Cout,
  output logic       PG,
  output logic       GG,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);

  assign PG   = &w_p;
  assign GG   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign Cout = GG | (PG & Cin);
  assign S    = w_p ^ w_c;

endmodule : CLA_4bit

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one CLA_4bit slice reused for WIDTH/4 cycles, LSB nibble first.
// Result, carry-out and signed overflow are valid while done is high.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t r_state;
  state_t w_next_state;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_b;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_sum;
  logic [IDX_W-1:0]                 r_idx;
  logic                             r_carry;
  logic                             r_cout;
  logic                             r_ovf;

  logic [NIBBLE_W-1:0] w_slice_s;
  logic                w_slice_cout;
  logic                w_accept;
  logic                w_last;
  logic                w_a_msb;

  // A new request is only taken when no operation is in flight.
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);
  assign w_a_msb  = r_a[NIBBLES-1][NIBBLE_W-1];

  CLA_4bit u_cla (
    .S    (w_slice_s),
    .Cout (w_slice_cout),
    .PG   (),
    .GG   (),
    .A    (r_a[r_idx]),
    .B    (r_b[r_idx]),
    .Cin  (r_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      // NOTE: every clocked register uses non-blocking assignment so all
      // state updates see pre-edge values regardless of statement order.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default first, so every path assigns w_next_state and no latch forms.
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (r_idx == LAST_IDX) w_next_state = DONE;
      DONE:    w_next_state = start ? RUN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx] <= w_slice_s;
      r_carry      <= w_slice_cout;
      r_idx        <= w_last ? '0 : r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_slice_cout;
        // Signed overflow: like-signed operands producing an opposite-signed sum.
        r_ovf  <= (w_a_msb == r_b[NIBBLES-1][NIBBLE_W-1]) &&
                  (w_slice_s[NIBBLE_W-1] != w_a_msb);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: expected results are queued at launch
// and compared against the DUT when done is observed.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc);
    exp_t       e;
    logic [W:0] full;
    full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input bit push);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    if (push) sb_q.push_back(model(ta, tb_v, tc));
  endtask

  // Drop start and disturb the operand inputs; a latched operation must not notice.
  task automatic scramble();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic finish_op(input string tag, input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, NIB + 1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check({tag, " sum"},  sum,  e.sum);
    check({tag, " cout"}, cout, e.cout);
    check({tag, " ovf"},  ovf,  e.ovf);
    check({tag, " busy"}, busy, 1'b0);
  endtask

  task automatic one_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_v, input logic tc);
    launch(ta, tb_v, tc, 1'b1);
    @(negedge clk);
    scramble();
    finish_op(tag, 1);
    @(negedge clk);
    check({tag, " done pulse"}, done, 1'b0);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int extra;
    extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check(tag, extra, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset sum",  sum,  '0);
    check("reset cout", cout, 1'b0);
    check("reset ovf",  ovf,  1'b0);
    rst = 1'b0;
    @(negedge clk);

    one_op("inc",     16'h0001, 16'h0000, 1'b0);
    one_op("carry",   16'hFFFF, 16'h0001, 1'b0);
    one_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
    one_op("mixed",   16'hABCD, 16'h1234, 1'b1);
    one_op("ovf_neg", 16'h8000, 16'h8000, 1'b0);
    one_op("cin_all", 16'hFFFF, 16'h0000, 1'b1);

    // Start pulsed while busy must be ignored.
    launch(16'h1111, 16'h2222, 1'b0, 1'b1);
    @(negedge clk);
    scramble();
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    check("ignore busy", busy, 1'b1);
    @(negedge clk);
    scramble();
    finish_op("ignore", 3);
    count_done("ignore extra done", 10);

    // Reset in the middle of a run aborts it.
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    scramble();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort sum",  sum,  '0);
    check("abort cout", cout, 1'b0);
    check("abort ovf",  ovf,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    count_done("abort no done", 10);
    check("abort idle", busy, 1'b0);
    one_op("after_rst", 16'h0005, 16'h0003, 1'b0);

    // Back-to-back: each new start issued in the DONE cycle.
    launch(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    @(negedge clk);
    scramble();
    finish_op("b2b0", 1);
    launch(16'h4000, 16'h4000, 1'b1, 1'b1);
    @(negedge clk);
    scramble();
    finish_op("b2b1", 1);
    launch(16'hFFF0, 16'h0010, 1'b0, 1'b1);
    @(negedge clk);
    scramble();
    finish_op("b2b2", 1);
    @(negedge clk);
    check("b2b done pulse", done, 1'b0);

    for (int i = 0; i < 4; i++) begin
      one_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_nibble_serial_adder
